pilha_retorno: RTL and testbench
================================

# pilha_retorno

Return-address stack that consumes link writes. On every JAL/JALR it captures the return address being written to link register $30. On every return (jump through $30) it pops and presents the predicted return target. It sits in the fetch/decode stage beside the destination-register selection logic, so the fetch unit can redirect on a return without waiting for the register-file read of $30.

## Interface
Parameters:
- LARGURA, 32, address width in bits
- PROFUNDIDADE, 8, number of entries; power of two, ≥ 2

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- jal  input  1  JAL in decode this cycle (link write to $30)
- jalr  input  1  JALR in decode this cycle (link write to $30)
- endereco_retorno  input  LARGURA  return address being linked (PC of next instruction)
- retorno  input  1  return instruction (jump through $30) in decode this cycle; pop request
- limpar  input  1  pipeline flush; empties the stack
- topo  output  LARGURA  current top-of-stack address (predicted return target)
- valido  output  1  topo holds a real entry (nivel ≠ 0)
- vazia  output  1  nivel == 0
- cheia  output  1  nivel == PROFUNDIDADE
- nivel  output  $clog2(PROFUNDIDADE+1)  number of valid entries

## Operation
- Storage is a circular buffer `mem[PROFUNDIDADE]`, write pointer `ptr` (next free slot, wraps modulo PROFUNDIDADE), and occupancy `nivel`.
- `push = jal | jalr`. `pop = retorno`.
- Priority per cycle: reset > limpar > push/pop.
- **limpar:** sets ptr = 0 and nivel = 0. mem contents are not cleared. Any same-cycle push or pop is ignored.
- **push only, not full:** mem[ptr] ← endereco_retorno; ptr+1; nivel+1.
- **push only, full:** mem[ptr] ← endereco_retorno, overwriting the oldest entry; ptr+1; nivel stays PROFUNDIDADE. This is an overflow event.
- **pop only, nivel > 0:** ptr−1 (wraps); nivel−1.
- **pop only, empty:** no state change. This is an underflow event.
- **push and pop, nivel > 0:** replace the top entry in place: mem[ptr−1] ← endereco_retorno. ptr and nivel are unchanged.
- **push and pop, empty:** treated as push only.
- **Outputs:**
  - topo = mem[ptr−1] when nivel > 0, else 0.
  - valido = (nivel ≠ 0).
  - vazia and cheia are decoded combinationally from nivel.
- Pointer arithmetic is modulo PROFUNDIDADE using a $clog2(PROFUNDIDADE)-bit counter with natural wrap. nivel never exceeds PROFUNDIDADE and never goes below 0.

## Timing
- Reset (reset = 0 at an edge): ptr = 0, nivel = 0, topo = 0, valido = 0, vazia = 1, cheia = 0. Statistic counters, when compiled in, also return to 0.
- Reset mid-operation discards all entries; the next cycle behaves as empty.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
- Push latency is 1 cycle: an address pushed at edge N appears on topo after edge N.
- Pop latency is 1 cycle: topo shows the next-older entry after the edge.
- Back-to-back push/pop on every cycle is supported with no stall and no handshake.

## Configuration
- Macro `PILHA_RETORNO_ESTATISTICA_EN`.
- **Defined:** adds two outputs.
  - contador_estouro (output, 16 bits) increments on each overflow event.
  - contador_vazio (output, 16 bits) increments on each underflow event.
  - Both saturate at 16'hFFFF, clear on reset, and are unaffected by limpar.
- **Undefined:** the ports and counters do not exist. Stack behaviour is identical in both cases.

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with jal = 1 → nivel = 0, topo = 0, vazia = 1, valido = 0.
- **Push/pop order:** push 0x100, 0x200, 0x300 on consecutive cycles, then pop 3 times → topo reads 0x300, then 0x200, then 0x100, then 0 with vazia = 1.
- **Overflow (PROFUNDIDADE = 8):** push 0x10..0x90 (9 values) → cheia = 1, nivel = 8. Popping 8 times yields 0x90 down to 0x20 and never 0x10. contador_estouro = 1 when the macro is defined.
- **Underflow:** pop on an empty stack 3 times → no state change, topo = 0. contador_vazio = 3 when the macro is defined.
- **Simultaneous push and pop:** with stack [0x100, 0x200], assert jalr = 1, retorno = 1, endereco_retorno = 0x500 → nivel stays 2, topo = 0x500. A following pop gives topo = 0x100.
- **Flush priority:** with nivel = 5, assert limpar = 1 together with jal = 1 → next cycle nivel = 0, vazia = 1, and the push is discarded.

Source files
------------

// File: rtl/pilha_retorno_if.sv
// Decode-side bundle for the return-address stack: link/return requests in,
// predicted return target and occupancy status out.
interface pilha_retorno_if #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned PROFUNDIDADE = 8
);
    localparam int unsigned NIVEL_W = $clog2(PROFUNDIDADE + 1);

    logic               jal;
    logic               jalr;
    logic [LARGURA-1:0] endereco_retorno;
    logic               retorno;
    logic               limpar;
    logic [LARGURA-1:0] topo;
    logic               valido;
    logic               vazia;
    logic               cheia;
    logic [NIVEL_W-1:0] nivel;

    // Decode stage drives requests and consumes the prediction
    modport master (
        output jal, jalr, endereco_retorno, retorno, limpar,
        input  topo, valido, vazia, cheia, nivel
    );

    // The stack consumes requests and presents the prediction
    modport slave (
        input  jal, jalr, endereco_retorno, retorno, limpar,
        output topo, valido, vazia, cheia, nivel
    );
endinterface

// File: rtl/pilha_retorno.sv
// Return-address stack fed by link writes to $30, popped on returns.
// Optional overflow/underflow counters under PILHA_RETORNO_ESTATISTICA_EN.
module pilha_retorno #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned PROFUNDIDADE = 8
) (
    input  logic            clock,
    input  logic            reset,
    pilha_retorno_if.slave  bus
`ifdef PILHA_RETORNO_ESTATISTICA_EN
    ,
    output logic [15:0]     contador_estouro,
    output logic [15:0]     contador_vazio
`endif
);
    localparam int unsigned PTR_W   = $clog2(PROFUNDIDADE);
    localparam int unsigned NIVEL_W = $clog2(PROFUNDIDADE + 1);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   ptr_topo;
    logic [NIVEL_W-1:0] nivel;
    logic [NIVEL_W-1:0] nivel_d;
    logic               push;
    logic               pop;
    logic               vazia_int;
    logic               cheia_int;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic               estouro;
    logic               vazio_ev;

    assign push      = bus.jal | bus.jalr;
    assign pop       = bus.retorno;
    assign ptr_topo  = ptr - PTR_W'(1);
    assign vazia_int = (nivel == NIVEL_W'(0));
    assign cheia_int = (nivel == NIVEL_W'(PROFUNDIDADE));

    // Next-state decode: limpar beats push/pop; push+pop on a live top rewrites it
    always_comb begin
        ptr_d    = ptr;
        nivel_d  = nivel;
        wr_en    = 1'b0;
        wr_addr  = ptr;
        estouro  = 1'b0;
        vazio_ev = 1'b0;
        if (bus.limpar) begin
            ptr_d   = '0;
            nivel_d = '0;
        end else if (push && pop && !vazia_int) begin
            wr_en   = 1'b1;
            wr_addr = ptr_topo;
        end else if (push) begin
            wr_en   = 1'b1;
            wr_addr = ptr;
            ptr_d   = ptr + PTR_W'(1);
            if (cheia_int) begin
                estouro = 1'b1;
            end else begin
                nivel_d = nivel + NIVEL_W'(1);
            end
        end else if (pop) begin
            if (vazia_int) begin
                vazio_ev = 1'b1;
            end else begin
                ptr_d   = ptr_topo;
                nivel_d = nivel - NIVEL_W'(1);
            end
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr   <= '0;
            nivel <= '0;
        end else begin
            ptr   <= ptr_d;
            nivel <= nivel_d;
        end
    end

    // Entry storage is never cleared; occupancy alone decides what is live
    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wr_addr] <= bus.endereco_retorno;
        end
    end

    assign bus.topo   = vazia_int ? '0 : mem[ptr_topo];
    assign bus.valido = !vazia_int;
    assign bus.vazia  = vazia_int;
    assign bus.cheia  = cheia_int;
    assign bus.nivel  = nivel;

`ifdef PILHA_RETORNO_ESTATISTICA_EN
    // Saturating event counters; survive limpar, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            contador_estouro <= '0;
            contador_vazio   <= '0;
        end else begin
            if (estouro && (contador_estouro != 16'hFFFF)) begin
                contador_estouro <= contador_estouro + 16'd1;
            end
            if (vazio_ev && (contador_vazio != 16'hFFFF)) begin
                contador_vazio <= contador_vazio + 16'd1;
            end
        end
    end
`else
    logic eventos_nao_usados;
    assign eventos_nao_usados = estouro ^ vazio_ev;
`endif

endmodule

// File: tb/tb_pilha_retorno.sv
// Directed bench for pilha_retorno: ordering, overflow, underflow,
// replace-on-push+pop, flush priority and reset.
module tb_pilha_retorno;
    localparam int unsigned LARGURA      = 32;
    localparam int unsigned PROFUNDIDADE = 8;

    logic clock;
    logic reset;
    int   checks;
    int   erros;

    pilha_retorno_if #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) bus ();

`ifdef PILHA_RETORNO_ESTATISTICA_EN
    logic [15:0] contador_estouro;
    logic [15:0] contador_vazio;
`endif

    pilha_retorno #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus              (bus)
`ifdef PILHA_RETORNO_ESTATISTICA_EN
        ,
        .contador_estouro (contador_estouro),
        .contador_vazio   (contador_vazio)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s obs=0x%0h esp=0x%0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic ocioso();
        bus.jal = 1'b0; bus.jalr = 1'b0; bus.retorno = 1'b0; bus.limpar = 1'b0;
    endtask

    task automatic empilhar(input logic [31:0] a);
        ocioso();
        bus.jal = 1'b1; bus.endereco_retorno = a;
        ciclo();
        ocioso();
    endtask

    task automatic desempilhar();
        ocioso();
        bus.retorno = 1'b1;
        ciclo();
        ocioso();
    endtask

    initial begin
        checks = 0;
        erros  = 0;
        ocioso();
        bus.endereco_retorno = 32'h0;

        // Reset held with a push pending
        reset = 1'b0;
        bus.jal = 1'b1; bus.endereco_retorno = 32'hABC;
        ciclo(); ciclo();
        verificar("rst_nivel",  32'(bus.nivel),  32'd0);
        verificar("rst_topo",   bus.topo,        32'h0);
        verificar("rst_vazia",  32'(bus.vazia),  32'd1);
        verificar("rst_valido", 32'(bus.valido), 32'd0);
        verificar("rst_cheia",  32'(bus.cheia),  32'd0);
        ocioso();
        reset = 1'b1;
        ciclo();
        verificar("rst_idle_nivel", 32'(bus.nivel), 32'd0);

        // LIFO order
        empilhar(32'h100);
        verificar("ord_topo1", bus.topo, 32'h100);
        empilhar(32'h200);
        empilhar(32'h300);
        verificar("ord_topo3",  bus.topo,       32'h300);
        verificar("ord_nivel3", 32'(bus.nivel), 32'd3);
        desempilhar();
        verificar("ord_pop1", bus.topo, 32'h200);
        desempilhar();
        verificar("ord_pop2", bus.topo, 32'h100);
        desempilhar();
        verificar("ord_pop3",   bus.topo,      32'h0);
        verificar("ord_vazia3", 32'(bus.vazia), 32'd1);

        // Overflow: ninth push drops 0x10
        for (int i = 1; i <= 9; i++) begin
            empilhar(32'(i * 16));
        end
        verificar("ovf_cheia", 32'(bus.cheia), 32'd1);
        verificar("ovf_nivel", 32'(bus.nivel), 32'd8);
        for (int k = 0; k < 8; k++) begin
            verificar($sformatf("ovf_topo%0d", k), bus.topo, 32'((9 - k) * 16));
            desempilhar();
        end
        verificar("ovf_fim_topo",  bus.topo,       32'h0);
        verificar("ovf_fim_vazia", 32'(bus.vazia), 32'd1);
`ifdef PILHA_RETORNO_ESTATISTICA_EN
        verificar("ovf_contador", 32'(contador_estouro), 32'd1);
`endif

        // Underflow: three pops on empty
        for (int k = 0; k < 3; k++) begin
            desempilhar();
        end
        verificar("unf_nivel", 32'(bus.nivel), 32'd0);
        verificar("unf_topo",  bus.topo,       32'h0);
`ifdef PILHA_RETORNO_ESTATISTICA_EN
        verificar("unf_contador", 32'(contador_vazio), 32'd3);
`endif

        // Push+pop replaces the top in place
        empilhar(32'h100);
        empilhar(32'h200);
        ocioso();
        bus.jalr = 1'b1; bus.retorno = 1'b1; bus.endereco_retorno = 32'h500;
        ciclo();
        ocioso();
        verificar("sim_nivel", 32'(bus.nivel), 32'd2);
        verificar("sim_topo",  bus.topo,       32'h500);
        desempilhar();
        verificar("sim_pop_topo", bus.topo, 32'h100);

        // Flush beats a same-cycle push
        for (int i = 0; i < 4; i++) begin
            empilhar(32'h1000 + 32'(i));
        end
        verificar("fl_nivel5", 32'(bus.nivel), 32'd5);
        ocioso();
        bus.limpar = 1'b1; bus.jal = 1'b1; bus.endereco_retorno = 32'h777;
        ciclo();
        ocioso();
        verificar("fl_nivel", 32'(bus.nivel), 32'd0);
        verificar("fl_vazia", 32'(bus.vazia), 32'd1);
        verificar("fl_topo",  bus.topo,       32'h0);
`ifdef PILHA_RETORNO_ESTATISTICA_EN
        verificar("fl_estouro", 32'(contador_estouro), 32'd1);
        verificar("fl_vazio",   32'(contador_vazio),   32'd3);
`endif

        // Push+pop on empty acts as a plain push
        ocioso();
        bus.jal = 1'b1; bus.retorno = 1'b1; bus.endereco_retorno = 32'h55;
        ciclo();
        ocioso();
        verificar("pp_vazia_nivel", 32'(bus.nivel), 32'd1);
        verificar("pp_vazia_topo",  bus.topo,       32'h55);
        empilhar(32'hAAA);
        verificar("pp_push_topo", bus.topo, 32'hAAA);

        // Reset mid-operation discards everything
        reset = 1'b0;
        ciclo();
        reset = 1'b1;
        verificar("rst2_nivel",  32'(bus.nivel),  32'd0);
        verificar("rst2_topo",   bus.topo,        32'h0);
        verificar("rst2_valido", 32'(bus.valido), 32'd0);
`ifdef PILHA_RETORNO_ESTATISTICA_EN
        verificar("rst2_estouro", 32'(contador_estouro), 32'd0);
        verificar("rst2_vazio",   32'(contador_vazio),   32'd0);
`endif
        empilhar(32'hBEEF);
        verificar("rst2_push_topo", bus.topo, 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end
endmodule
